// File: rtl/addn_pipe_pkg.sv
// -----------------------------------------------------------------------------
// addn_pipe_pkg
// Shared sha512 definitions for the multi-operand adder family:
//   - SHA512_WIDTH : natural operand width of the sha512 datapath
//   - ADDN_LAT     : pipeline latency of addn_pipe for a given SPLIT setting
//   - addn_ops_legal() : legal NUM_OPS range check used at elaboration
// -----------------------------------------------------------------------------
`ifndef ADDN_LAT
`define ADDN_LAT(split) (32'd1 + (split))
`endif

package addn_pipe_pkg;

    localparam int unsigned SHA512_WIDTH = 32'd64;
    localparam int unsigned ADDN_MIN_OPS = 32'd2;
    localparam int unsigned ADDN_MAX_OPS = 32'd5;

    // Cycles from accept to out_valid.
    function automatic int unsigned addn_lat(input int unsigned split);
        return `ADDN_LAT(split);
    endfunction

    function automatic bit addn_ops_legal(input int unsigned n);
        return (n >= ADDN_MIN_OPS) && (n <= ADDN_MAX_OPS);
    endfunction

endpackage

// File: rtl/addn_pipe_csa32.sv
// -----------------------------------------------------------------------------
// addn_pipe_csa32
// 3:2 carry-save compressor, purely combinational.
//   a_i, b_i, c_i : three WIDTH-bit addends
//   sum_o         : bitwise sum vector
//   carry_o       : majority vector shifted up one place (top carry dropped,
//                   the adder works modulo 2^WIDTH)
// a_i + b_i + c_i == sum_o + carry_o  (mod 2^WIDTH)
// -----------------------------------------------------------------------------
module addn_pipe_csa32
    import addn_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = SHA512_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);

    logic [WIDTH-1:0] maj_s;

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign maj_s   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign carry_o = maj_s << 1'b1;

endmodule

// File: rtl/addn_pipe.sv
// -----------------------------------------------------------------------------
// addn_pipe
// Multi-operand modular adder for the sha512crypt datapath. Sums NUM_OPS
// operands (plus the current o when acc_en) modulo 2^WIDTH.
//   CLK, rst       : clock, synchronous active-high reset (o <= IV)
//   clr            : synchronous flush, same effect as rst, blocks input
//   in_valid/ready : operand bundle handshake; ops operand i at [i*WIDTH +: WIDTH]
//   acc_en         : add current o as an extra operand (held off until the
//                    pipeline ahead of o is empty)
//   out_valid/ready: result handshake on o
// SPLIT=1: stage 1 = CSA tree + low-half add, stage 2 = high half + carry.
// SPLIT=0: single stage, full add straight into o.
// -----------------------------------------------------------------------------
module addn_pipe
    import addn_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = SHA512_WIDTH,
    parameter int unsigned      NUM_OPS = 32'd3,
    parameter logic [WIDTH-1:0] IV      = {WIDTH{1'b0}},
    parameter int unsigned      SPLIT   = 32'd1
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] ops,
    input  logic                     acc_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         o
);

    localparam bit          USE_SPLIT = (addn_lat(SPLIT) == 32'd2);
    localparam int unsigned LO_W      = WIDTH / 32'd2;
    localparam int unsigned HI_W      = WIDTH - LO_W;
    // The accumulator term is always present in the tree, zeroed when unused.
    localparam int unsigned NUM_TERMS = NUM_OPS + 32'd1;
    localparam int unsigned NUM_CSA   = NUM_TERMS - 32'd2;

    if (!addn_ops_legal(NUM_OPS)) begin : g_bad_num_ops
        $error("addn_pipe: NUM_OPS must be within 2..5");
    end
    if (USE_SPLIT && ((WIDTH % 32'd2) != 32'd0)) begin : g_bad_width
        $error("addn_pipe: WIDTH must be even when SPLIT=1");
    end

    // ---------------- state ----------------
    logic [WIDTH-1:0] o_q,         o_d;
    logic             out_valid_q, out_valid_d;
    logic             s1_valid_q,  s1_valid_d;
    logic [LO_W-1:0]  s1_lo_q,     s1_lo_d;
    logic [HI_W-1:0]  s1_sum_hi_q, s1_sum_hi_d;
    logic [HI_W-1:0]  s1_cry_hi_q, s1_cry_hi_d;
    logic             s1_cy_q,     s1_cy_d;

    // ---------------- carry-save reduction ----------------
    logic [WIDTH-1:0] term_s    [NUM_TERMS];
    logic [WIDTH-1:0] csa_sum_s [NUM_CSA+1];
    logic [WIDTH-1:0] csa_cry_s [NUM_CSA+1];
    logic [WIDTH-1:0] sum_vec_s;
    logic [WIDTH-1:0] cry_vec_s;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_term
        assign term_s[i] = ops[i*WIDTH +: WIDTH];
    end
    assign term_s[NUM_OPS] = acc_en ? o_q : {WIDTH{1'b0}};

    // Chain: each compressor folds the next term into the running sum/carry pair.
    assign csa_sum_s[0] = term_s[0];
    assign csa_cry_s[0] = term_s[1];
    for (genvar k = 0; k < NUM_CSA; k++) begin : g_csa
        addn_pipe_csa32 #(.WIDTH(WIDTH)) u_csa (
            .a_i     (csa_sum_s[k]),
            .b_i     (csa_cry_s[k]),
            .c_i     (term_s[k+2]),
            .sum_o   (csa_sum_s[k+1]),
            .carry_o (csa_cry_s[k+1])
        );
    end
    assign sum_vec_s = csa_sum_s[NUM_CSA];
    assign cry_vec_s = csa_cry_s[NUM_CSA];

    // ---------------- carry-propagate adders ----------------
    logic [LO_W:0]    lo_sum_s;
    logic [HI_W-1:0]  hi_sum_s;
    logic [WIDTH-1:0] full_sum_s;

    // Low-half add (stage 1), high-half add with registered carry (stage 2), full add (SPLIT=0).
    always_comb begin
        lo_sum_s   = {1'b0, sum_vec_s[LO_W-1:0]} + {1'b0, cry_vec_s[LO_W-1:0]};
        hi_sum_s   = s1_sum_hi_q + s1_cry_hi_q + HI_W'(s1_cy_q);
        full_sum_s = sum_vec_s + cry_vec_s;
    end

    // ---------------- handshake ----------------
    logic stall_s;
    logic s1_adv_s;
    logic accept_s;

    assign stall_s  = out_valid_q && !out_ready;
    assign s1_adv_s = s1_valid_q && !stall_s;
    assign accept_s = in_valid && in_ready;

    // Input acceptance: blocked by flush, by a full stage that cannot drain,
    // and for acc_en until o holds the fully retired previous result.
    always_comb begin
        if (USE_SPLIT) begin
            in_ready = !clr && !(s1_valid_q && stall_s) && !(acc_en && s1_valid_q);
        end else begin
            in_ready = !clr && !stall_s;
        end
    end

    // Next-state for stage 1 and the output register.
    always_comb begin
        o_d         = o_q;
        out_valid_d = out_valid_q;
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_sum_hi_d = s1_sum_hi_q;
        s1_cry_hi_d = s1_cry_hi_q;
        s1_cy_d     = s1_cy_q;
        if (USE_SPLIT) begin
            if (accept_s) begin
                s1_valid_d  = 1'b1;
                s1_lo_d     = lo_sum_s[LO_W-1:0];
                s1_cy_d     = lo_sum_s[LO_W];
                s1_sum_hi_d = sum_vec_s[WIDTH-1:LO_W];
                s1_cry_hi_d = cry_vec_s[WIDTH-1:LO_W];
            end else if (s1_adv_s) begin
                s1_valid_d = 1'b0;
            end else begin
                s1_valid_d = s1_valid_q;
            end

            if (stall_s) begin
                out_valid_d = out_valid_q;
            end else if (s1_valid_q) begin
                o_d         = {hi_sum_s, s1_lo_q};
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (stall_s) begin
                out_valid_d = out_valid_q;
            end else if (accept_s) begin
                o_d         = full_sum_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; rst and clr both flush every stage and reload IV.
    always_ff @(posedge CLK) begin
        if (rst || clr) begin
            o_q         <= IV;
            out_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= {LO_W{1'b0}};
            s1_sum_hi_q <= {HI_W{1'b0}};
            s1_cry_hi_q <= {HI_W{1'b0}};
            s1_cy_q     <= 1'b0;
        end else begin
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_sum_hi_q <= s1_sum_hi_d;
            s1_cry_hi_q <= s1_cry_hi_d;
            s1_cy_q     <= s1_cy_d;
        end
    end

    assign o         = o_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_addn_pipe.sv
// -----------------------------------------------------------------------------
// tb_addn_pipe
// Directed bench for addn_pipe: a default instance (SPLIT=1, NUM_OPS=3, IV=0),
// an IV instance (IV = sha512 H0) and a NUM_OPS=5 / SPLIT=0 instance.
// -----------------------------------------------------------------------------
module tb_addn_pipe;

    localparam logic [63:0] IV_H0 = 64'h6a09_e667_f3bc_c908;

    logic CLK;
    logic rst;

    // default instance
    logic         clr, in_valid, acc_en, out_ready;
    logic [191:0] ops;
    logic         in_ready, out_valid;
    logic [63:0]  o;

    // IV instance
    logic         iv_clr, iv_in_valid, iv_acc_en;
    logic [191:0] iv_ops;
    logic         iv_in_ready, iv_out_valid;
    logic [63:0]  iv_o;

    // five-operand single-stage instance
    logic         f_clr, f_in_valid, f_acc_en, f_out_ready;
    logic [319:0] f_ops;
    logic         f_in_ready, f_out_valid;
    logic [63:0]  f_o;

    int n_checks;
    int n_fail;

    addn_pipe u_dut (
        .CLK(CLK), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .ops(ops), .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready), .o(o)
    );

    addn_pipe #(.IV(IV_H0)) u_dut_iv (
        .CLK(CLK), .rst(rst), .clr(iv_clr), .in_valid(iv_in_valid), .in_ready(iv_in_ready),
        .ops(iv_ops), .acc_en(iv_acc_en), .out_valid(iv_out_valid), .out_ready(1'b1), .o(iv_o)
    );

    addn_pipe #(.NUM_OPS(5), .SPLIT(0)) u_dut5 (
        .CLK(CLK), .rst(rst), .clr(f_clr), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .ops(f_ops), .acc_en(f_acc_en), .out_valid(f_out_valid), .out_ready(f_out_ready), .o(f_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Results handed over on the default instance, captured mid-cycle.
    logic [63:0] got_q [$];
    bit          mon_en;
    always @(negedge CLK) begin
        if (mon_en && out_valid && out_ready) got_q.push_back(o);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [63:0] vc [4];

    // Streams n bundles from va/vb/vc; out_ready low for cycles st_lo..st_hi.
    // blocked counts cycles where a bundle was offered but not taken.
    task automatic run_stream(input int n, input bit acc, input int st_lo, input int st_hi,
                              output int blocked);
        int idx;
        bit take;
        idx     = 0;
        blocked = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            in_valid  = (idx < n);
            acc_en    = acc;
            if (idx < n) ops = {vc[idx], vb[idx], va[idx]};
            out_ready = !((cyc >= st_lo) && (cyc <= st_hi));
            #1;
            take = in_valid && in_ready;
            if (in_valid && !in_ready) blocked++;
            step();
            if (take) idx++;
        end
        in_valid  = 1'b0;
        acc_en    = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int blocked;
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst = 1'b1;
        clr = 1'b0; in_valid = 1'b0; acc_en = 1'b0; out_ready = 1'b1; ops = '0;
        iv_clr = 1'b0; iv_in_valid = 1'b0; iv_acc_en = 1'b0; iv_ops = '0;
        f_clr = 1'b0; f_in_valid = 1'b0; f_acc_en = 1'b0; f_out_ready = 1'b1; f_ops = '0;

        // ---- reset state ----
        step();
        step();
        rst = 1'b0;
        check_eq("rst_o", o, 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_iv_o", iv_o, IV_H0);
        check_eq("rst_iv_out_valid", 64'(iv_out_valid), 64'd0);
        check_eq("rst_f_o", f_o, 64'd0);
        check_eq("rst_f_out_valid", 64'(f_out_valid), 64'd0);

        // ---- basic sum, latency 2, back-to-back with wraparound ----
        ops = {64'd3, 64'd2, 64'd1};
        in_valid = 1'b1;
        #1;
        check_eq("t1_in_ready", 64'(in_ready), 64'd1);
        step();
        ops = {64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        check_eq("t1_valid_lat1", 64'(out_valid), 64'd0);
        step();
        in_valid = 1'b0;
        check_eq("t1_valid_lat2", 64'(out_valid), 64'd1);
        check_eq("t1_sum6", o, 64'd6);
        step();
        check_eq("t1_valid_b2b", 64'(out_valid), 64'd1);
        check_eq("t1_wrap0", o, 64'd0);
        step();
        check_eq("t1_valid_drop", 64'(out_valid), 64'd0);

        // ---- carry across the half boundary ----
        ops = {64'd0, 64'd1, 64'h0000_0000_FFFF_FFFF};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("t2_valid", 64'(out_valid), 64'd1);
        check_eq("t2_half_carry", o, 64'h0000_0001_0000_0000);
        step();

        // ---- backpressure: 4 bundles, out_ready low 3 cycles ----
        va[0] = 64'd1;  vb[0] = 64'd2;  vc[0] = 64'd7;
        va[1] = 64'd5;  vb[1] = 64'd5;  vc[1] = 64'd10;
        va[2] = 64'd10; vb[2] = 64'd10; vc[2] = 64'd10;
        va[3] = 64'd0;  vb[3] = 64'd15; vc[3] = 64'd25;
        got_q.delete();
        mon_en = 1'b1;
        run_stream(4, 1'b0, 2, 4, blocked);
        mon_en = 1'b0;
        check_eq("bp_blocked", 64'(blocked), 64'd3);
        check_eq("bp_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("bp_res%0d", i), (i < got_q.size()) ? got_q[i] : 64'hDEAD,
                     64'd10 * 64'(i + 1));
        end

        // ---- accumulate after clr ----
        clr = 1'b1;
        #1;
        check_eq("clr_in_ready", 64'(in_ready), 64'd0);
        step();
        clr = 1'b0;
        check_eq("clr_o", o, 64'd0);
        va[0] = 64'd5; vb[0] = 64'd0; vc[0] = 64'd0;
        va[1] = 64'd5; vb[1] = 64'd0; vc[1] = 64'd0;
        got_q.delete();
        mon_en = 1'b1;
        run_stream(2, 1'b1, 99, 98, blocked);
        mon_en = 1'b0;
        check_eq("acc_blocked", 64'(blocked), 64'd1);
        check_eq("acc_count", 64'(got_q.size()), 64'd2);
        check_eq("acc_res5", (got_q.size() > 0) ? got_q[0] : 64'hDEAD, 64'd5);
        check_eq("acc_res10", (got_q.size() > 1) ? got_q[1] : 64'hDEAD, 64'd10);

        // ---- reset mid-flight ----
        ops = {64'd9, 64'd8, 64'd7};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_o", o, 64'd0);
        step();
        step();
        check_eq("mid_rst_lost", 64'(out_valid), 64'd0);
        ops = {64'd300, 64'd200, 64'd100};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_eq("post_rst_valid", 64'(out_valid), 64'd1);
        check_eq("post_rst_sum", o, 64'd600);

        // ---- IV instance: clr then accumulate ----
        iv_clr = 1'b1;
        step();
        iv_clr = 1'b0;
        check_eq("iv_clr_o", iv_o, IV_H0);
        iv_ops = {64'd0, 64'd0, 64'd1};
        iv_acc_en = 1'b1;
        iv_in_valid = 1'b1;
        #1;
        check_eq("iv_in_ready", 64'(iv_in_ready), 64'd1);
        step();
        iv_in_valid = 1'b0;
        iv_acc_en = 1'b0;
        step();
        check_eq("iv_acc_valid", 64'(iv_out_valid), 64'd1);
        check_eq("iv_acc_o", iv_o, 64'h6a09_e667_f3bc_c909);

        // ---- NUM_OPS=5, SPLIT=0 ----
        f_ops = {64'd5, 64'd4, 64'd3, 64'd2, 64'd1};
        f_in_valid = 1'b1;
        step();
        f_in_valid = 1'b0;
        check_eq("f_valid_lat1", 64'(f_out_valid), 64'd1);
        check_eq("f_sum15", f_o, 64'd15);
        f_out_ready = 1'b0;
        #1;
        check_eq("f_stall_ready", 64'(f_in_ready), 64'd0);
        f_out_ready = 1'b1;
        f_clr = 1'b1;
        f_in_valid = 1'b1;
        #1;
        check_eq("f_clr_ready", 64'(f_in_ready), 64'd0);
        step();
        f_clr = 1'b0;
        f_in_valid = 1'b0;
        check_eq("f_hs_clr_valid", 64'(f_out_valid), 64'd0);
        check_eq("f_hs_clr_o", f_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
